// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - triangle-sweep sequencer driving an up/down counter's P_C/U_D lines.
// Turning-point dwell states are built only when SWEEP_CTRL_DWELL_EN is defined.
module sweep_ctrl #(
  parameter int WIDTH = 8,
  parameter int DWELL = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] LO,
  input  logic [WIDTH-1:0] HI,
  input  logic [3:0]       PASSES,
  input  logic [WIDTH-1:0] Q,
  output logic             P_C,
  output logic             U_D,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  if (DWELL < 1 || DWELL > 15) begin : g_dwell_range
    $error("sweep_ctrl: DWELL must be in 1..15");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEEK,
    S_UP,
    S_DOWN,
    S_FIN
`ifdef SWEEP_CTRL_DWELL_EN
    , S_DWELL_HI,
    S_DWELL_LO
`endif
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [3:0]       r_rem;
  logic             r_pc;
  logic             r_ud;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] w_qn;
  logic             w_pc;
  logic             w_ud;
  logic             w_busy;
  logic             w_done;
  logic             w_err;
`ifdef SWEEP_CTRL_DWELL_EN
  logic [3:0]       r_dwell;
  logic             w_dwell_last;
  assign w_dwell_last = (r_dwell == 4'(DWELL - 1));
`endif

  // Value Q will hold after this edge; every arrival test looks ahead with it.
  assign w_qn = r_pc ? Q : (r_ud ? Q + 1'b1 : Q - 1'b1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_lo    <= '0;
      r_hi    <= '0;
      r_rem   <= 4'd0;
      r_pc    <= 1'b1;
      r_ud    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef SWEEP_CTRL_DWELL_EN
      r_dwell <= 4'd0;
`endif
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc;
      r_ud    <= w_ud;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
      if (r_state == S_IDLE && w_next == S_SEEK) begin
        r_lo  <= LO;
        r_hi  <= HI;
        r_rem <= PASSES;
      end
      if (r_state == S_DOWN && w_qn == r_lo) begin
        r_rem <= r_rem - 4'd1;
      end
`ifdef SWEEP_CTRL_DWELL_EN
      if (w_next != r_state) begin
        r_dwell <= 4'd0;
      end else if (r_state == S_DWELL_HI || r_state == S_DWELL_LO) begin
        r_dwell <= r_dwell + 4'd1;
      end
`endif
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (START && LO <= HI) w_next = S_SEEK;
      S_SEEK: if (w_qn == r_lo) w_next = (r_rem == 4'd0) ? S_FIN : S_UP;
`ifdef SWEEP_CTRL_DWELL_EN
      S_UP:       if (w_qn == r_hi) w_next = S_DWELL_HI;
      S_DWELL_HI: if (w_dwell_last) w_next = S_DOWN;
      S_DOWN:     if (w_qn == r_lo) w_next = S_DWELL_LO;
      S_DWELL_LO: if (w_dwell_last) w_next = (r_rem == 4'd0) ? S_FIN : S_UP;
`else
      S_UP:   if (w_qn == r_hi) w_next = S_DOWN;
      S_DOWN: if (w_qn == r_lo) w_next = (r_rem == 4'd1) ? S_FIN : S_UP;
`endif
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Moves are issued for the state being entered, so turns and restarts cost no hold cycle.
  always_comb begin
    w_pc   = 1'b1;
    w_ud   = r_ud;
    w_busy = (r_state != S_IDLE);
    w_done = (r_state == S_FIN);
    w_err  = (r_state == S_IDLE) && START && (LO > HI);
    if (r_state != S_IDLE) begin
      case (w_next)
        S_SEEK: if (w_qn != r_lo) begin w_pc = 1'b0; w_ud = (w_qn < r_lo); end
        S_UP:   if (w_qn != r_hi) begin w_pc = 1'b0; w_ud = 1'b1; end
        S_DOWN: if (w_qn != r_lo) begin w_pc = 1'b0; w_ud = 1'b0; end
        default: ;
      endcase
    end
  end

  assign P_C  = r_pc;
  assign U_D  = r_ud;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign ERR  = r_err;

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb/tb_sweep_ctrl.sv - randomized bench for sweep_ctrl against a trajectory-level model.
`timescale 1ns/1ps
module tb_sweep_ctrl;
  localparam int W  = 8;
  localparam int DW = 4;
`ifdef SWEEP_CTRL_DWELL_EN
  localparam bit DW_EN = 1'b1;
`else
  localparam bit DW_EN = 1'b0;
`endif

  typedef int iq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] lo;
  logic [7:0] hi;
  logic [3:0] passes;
  logic [7:0] q;
  logic       p_c;
  logic       u_d;
  logic       busy;
  logic       done;
  logic       err;
  logic       ld;
  logic [7:0] ld_val;

  int errors = 0;
  int checks = 0;

  int  m_held;
  iq_t m_q;
  int  m_phase;
  bit  m_busy;
  bit  m_done;
  bit  m_err;
  bit  m_qvalid;

  sweep_ctrl #(.WIDTH(W), .DWELL(DW)) dut (
    .CLK(clk), .RST(rst), .START(start), .LO(lo), .HI(hi), .PASSES(passes),
    .Q(q), .P_C(p_c), .U_D(u_d), .BUSY(busy), .DONE(done), .ERR(err)
  );

  always #5 clk = ~clk;

  // The counter being steered; its load path stands in for system-side control.
  always_ff @(posedge clk) begin
    if (ld) q <= ld_val;
    else if (!p_c) q <= u_d ? q + 8'd1 : q - 8'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Q value after each edge from the accepting edge on; DONE follows the last entry.
  function automatic iq_t build(input int q0, input int l, input int h, input int np,
                                input bit den, input int d);
    iq_t s;
    int  v;
    s.push_back(q0);
    s.push_back(q0);
    v = q0;
    while (v != l) begin
      v += (v < l) ? 1 : -1;
      s.push_back(v);
    end
    for (int p = 0; p < np; p++) begin
      if (l == h) begin
        repeat (2 + (den ? 2 * d : 0)) s.push_back(l);
      end else begin
        for (int x = l + 1; x <= h; x++) s.push_back(x);
        if (den) repeat (d) s.push_back(h);
        for (int x = h - 1; x >= l; x--) s.push_back(x);
        if (den) repeat (d) s.push_back(l);
      end
    end
    return s;
  endfunction

  initial begin
    m_phase = 0; m_busy = 0; m_done = 0; m_err = 0; m_qvalid = 0; m_held = 0;
    forever begin
      @(posedge clk);
      m_done = 0;
      m_err  = 0;
      if (ld) begin
        m_held   = int'(ld_val);
        m_qvalid = 1;
      end
      if (rst) begin
        if (m_q.size() > 0) m_held = m_q.pop_front();
        m_q.delete();
        m_phase = 0;
        m_busy  = 0;
      end else if (m_phase == 0) begin
        m_busy = 0;
        if (start) begin
          if (lo > hi) m_err = 1;
          else begin
            m_q     = build(m_held, int'(lo), int'(hi), int'(passes), DW_EN, DW);
            m_held  = m_q.pop_front();
            m_phase = 1;
          end
        end
      end else if (m_q.size() > 0) begin
        m_held = m_q.pop_front();
        m_busy = 1;
      end else begin
        m_done  = 1;
        m_busy  = 1;
        m_phase = 0;
      end
    end
  end

  initial begin : cmp
    logic e_pc;
    forever begin
      @(negedge clk);
      e_pc = (m_phase == 1 && m_q.size() > 0) ? (m_q[0] == m_held) : 1'b1;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("p_c", 32'(p_c), 32'(e_pc));
      if (!e_pc) chk("u_d", 32'(u_d), 32'(m_q[0] > m_held));
      if (m_qvalid) chk("q", 32'(q), 32'(m_held));
    end
  end

  task automatic load_q(input int v);
    @(negedge clk);
    ld = 1'b1;
    ld_val = 8'(v);
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic do_run(input int l, input int h, input int np, input bit noise, input int rst_at);
    bit fin;
    fin = 0;
    @(negedge clk);
    lo = 8'(l); hi = 8'(h); passes = 4'(np); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (m_phase == 0 && !m_busy) fin = 1;
      else begin
        if (c == rst_at) rst = 1'b1;
        if (noise && m_phase == 1 && $urandom_range(0, 15) == 0) begin
          start = 1'b1; lo = 8'($urandom); hi = 8'($urandom); passes = 4'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
      end
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL run_timeout: run lo=%0d hi=%0d passes=%0d never returned idle", l, h, np);
    end
  endtask

  initial begin : stim
    iq_t s;
    int  exp_dw[19] = '{0, 0, 1, 2, 3, 4, 5, 6, 6, 6, 6, 6, 5, 4, 3, 3, 3, 3, 3};
    int  exp_nd[10] = '{0, 0, 1, 2, 1, 0, 1, 2, 1, 0};
    int  l, h, np, ra;
    bit  down_seen;
    rst = 1'b1; ld = 1'b1; ld_val = 8'd0; start = 1'b0; lo = 8'd0; hi = 8'd0; passes = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0; ld = 1'b0;
    chk("reset_pc", 32'(p_c), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    s = build(0, 3, 6, 1, 1'b1, 4);
    chk("model_dwell_len", 32'(s.size()), 32'd19);
    for (int i = 0; i < 19 && i < s.size(); i++) chk("model_dwell_q", 32'(s[i]), 32'(exp_dw[i]));
    s = build(0, 0, 2, 2, 1'b0, 4);
    chk("model_nodwell_len", 32'(s.size()), 32'd10);
    for (int i = 0; i < 10 && i < s.size(); i++) chk("model_nodwell_q", 32'(s[i]), 32'(exp_nd[i]));
    s = build(200, 10, 10, 0, 1'b0, 4);
    chk("model_seek_len", 32'(s.size()), 32'd192);

    load_q(0);
    do_run(3, 6, 1, 1'b0, -1);
    chk("dwell_case_end_q", 32'(q), 32'd3);
    load_q(0);
    do_run(0, 2, 2, 1'b0, -1);
    chk("nodwell_case_end_q", 32'(q), 32'd0);

    load_q(200);
    do_run(10, 10, 0, 1'b0, -1);
    chk("seek_down_q", 32'(q), 32'd10);
    repeat (3) @(negedge clk);
    chk("seek_down_hold", 32'(q), 32'd10);

    @(negedge clk);
    lo = 8'd9; hi = 8'd4; passes = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("err_once", 32'(err), 32'd0);
    chk("err_q_hold", 32'(q), 32'd10);

    load_q(0);
    @(negedge clk);
    lo = 8'd1; hi = 8'd4; passes = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    lo = 8'd0; hi = 8'd9; passes = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_run(0, 0, 0, 1'b0, -1);
    chk("busy_start_end_q", 32'(q), 32'd1);

    load_q(0);
    @(negedge clk);
    lo = 8'd2; hi = 8'd5; passes = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    down_seen = 0;
    for (int c = 0; c < 200 && !down_seen; c++) begin
      if (m_phase == 1 && m_q.size() > 0 && m_q[0] < m_held) down_seen = 1;
      else @(negedge clk);
    end
    chk("reset_reached_down", 32'(down_seen), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_pc", 32'(p_c), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (4) @(negedge clk);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 2) != 0) load_q(int'($urandom_range(0, 255)));
      l  = int'($urandom_range(0, 60));
      h  = l + int'($urandom_range(0, 12));
      np = int'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0 && l != h) begin
        ra = l; l = h; h = ra;
      end
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 60)) : -1;
      do_run(l, h, np, 1'b1, ra);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
